// File: rtl/regfile_mw_pkg.sv
// Shared constants and helpers for the multi-lane rename register file.
// The optional same-cycle commit bypass is enabled by defining REGFILE_COMMIT_BYPASS_EN.
package regfile_mw_pkg;

  localparam int unsigned RegWidth      = 32;  // architectural value width
  localparam int unsigned IDWidth       = 5;   // register index width
  localparam int unsigned ROBWidth      = 4;   // reorder-buffer tag width
  localparam int unsigned RegCount      = 32;  // must equal 2**IDWidth
  localparam int unsigned DispatchWidth = 2;
  localparam int unsigned CommitWidth   = 2;

  // One bit set for every lane strictly older than `lane`.
  function automatic logic [31:0] lanes_below(input int unsigned lane);
    return (32'd1 << lane) - 32'd1;
  endfunction

endpackage

// File: rtl/regfile_mw_read.sv
// Single source-operand lookup: x0, intra-bundle rename forwarding, optional commit
// bypass (REGFILE_COMMIT_BYPASS_EN), then the stored array contents.
module regfile_mw_read
  import regfile_mw_pkg::*;
#(
  parameter int unsigned DISPATCH_WIDTH = DispatchWidth,
  parameter int unsigned COMMIT_WIDTH   = CommitWidth,
  parameter int unsigned REG_COUNT      = RegCount,
  parameter int unsigned REG_W          = IDWidth,
  parameter int unsigned DATA_W         = RegWidth,
  parameter int unsigned ROB_W          = ROBWidth
) (
  input  logic [REG_W-1:0]                 idx_i,
  input  logic [DATA_W-1:0]                values_i [REG_COUNT],
  input  logic [REG_COUNT-1:0]             busy_i,
  input  logic [ROB_W-1:0]                 tags_i [REG_COUNT],
  // Rename enables are pre-masked to lanes older than the reading lane.
  input  logic [DISPATCH_WIDTH-1:0]        ren_en_i,
  input  logic [DISPATCH_WIDTH*REG_W-1:0]  ren_rd_i,
  input  logic [DISPATCH_WIDTH*ROB_W-1:0]  ren_tag_i,
  input  logic [COMMIT_WIDTH-1:0]          cmt_en_i,
  input  logic [COMMIT_WIDTH*REG_W-1:0]    cmt_d_i,
  input  logic [COMMIT_WIDTH*DATA_W-1:0]   cmt_value_i,
  input  logic [COMMIT_WIDTH*ROB_W-1:0]    cmt_h_i,
  output logic                             busy_o,
  output logic [DATA_W-1:0]                value_o,
  output logic [ROB_W-1:0]                 tag_o
);

  logic             ren_hit;
  logic [ROB_W-1:0] ren_tag;

  // Ascending scan so the youngest matching older lane wins.
  always_comb begin
    ren_hit = 1'b0;
    ren_tag = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (ren_en_i[i] && (ren_rd_i[i*REG_W +: REG_W] == idx_i)) begin
        ren_hit = 1'b1;
        ren_tag = ren_tag_i[i*ROB_W +: ROB_W];
      end
    end
  end

  logic              byp_hit;
  logic [DATA_W-1:0] byp_value;

`ifdef REGFILE_COMMIT_BYPASS_EN
  logic             byp_sel;
  logic [ROB_W-1:0] byp_h;

  always_comb begin
    byp_sel   = 1'b0;
    byp_value = '0;
    byp_h     = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (cmt_en_i[k] && (cmt_d_i[k*REG_W +: REG_W] == idx_i)) begin
        byp_sel   = 1'b1;
        byp_value = cmt_value_i[k*DATA_W +: DATA_W];
        byp_h     = cmt_h_i[k*ROB_W +: ROB_W];
      end
    end
  end

  assign byp_hit = byp_sel && (byp_h == tags_i[idx_i]);
`else
  logic unused_commit;
  assign unused_commit = ^{cmt_en_i, cmt_d_i, cmt_value_i, cmt_h_i};
  assign byp_hit       = 1'b0;
  assign byp_value     = '0;
`endif

  always_comb begin
    busy_o  = 1'b0;
    value_o = '0;
    tag_o   = '0;
    if (idx_i != '0) begin
      if (ren_hit) begin
        busy_o = 1'b1;
        tag_o  = ren_tag;
      end else if (byp_hit) begin
        value_o = byp_value;
      end else begin
        busy_o  = busy_i[idx_i];
        value_o = values_i[idx_i];
        tag_o   = tags_i[idx_i];
      end
    end
  end

endmodule

// File: rtl/regfile_mw.sv
// Multi-lane register file with busy/ROB-tag rename state for Tomasulo dispatch.
// Define REGFILE_COMMIT_BYPASS_EN to let reads see same-cycle commits.
module regfile_mw
  import regfile_mw_pkg::*;
#(
  parameter int unsigned DISPATCH_WIDTH = DispatchWidth,
  parameter int unsigned COMMIT_WIDTH   = CommitWidth,
  parameter int unsigned REG_COUNT      = RegCount,
  parameter int unsigned REG_W          = IDWidth,
  parameter int unsigned DATA_W         = RegWidth,
  parameter int unsigned ROB_W          = ROBWidth
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic [DISPATCH_WIDTH*REG_W-1:0]  dispatcher_regfile_rs_in,
  input  logic [DISPATCH_WIDTH*REG_W-1:0]  dispatcher_regfile_rt_in,
  output logic [DISPATCH_WIDTH-1:0]        regfile_dispatcher_rs_busy_out,
  output logic [DISPATCH_WIDTH-1:0]        regfile_dispatcher_rt_busy_out,
  output logic [DISPATCH_WIDTH*DATA_W-1:0] regfile_dispatcher_rs_out,
  output logic [DISPATCH_WIDTH*DATA_W-1:0] regfile_dispatcher_rt_out,
  output logic [DISPATCH_WIDTH*ROB_W-1:0]  regfile_dispatcher_rs_reorder_out,
  output logic [DISPATCH_WIDTH*ROB_W-1:0]  regfile_dispatcher_rt_reorder_out,
  input  logic [DISPATCH_WIDTH-1:0]        dispatcher_regfile_rd_en_in,
  input  logic [DISPATCH_WIDTH*REG_W-1:0]  dispatcher_regfile_rd_in,
  input  logic [DISPATCH_WIDTH*ROB_W-1:0]  dispatcher_regfile_reorder_in,
  input  logic [COMMIT_WIDTH-1:0]          rob_regfile_en_in,
  input  logic [COMMIT_WIDTH*REG_W-1:0]    rob_regfile_d_in,
  input  logic [COMMIT_WIDTH*DATA_W-1:0]   rob_regfile_value_in,
  input  logic [COMMIT_WIDTH*ROB_W-1:0]    rob_regfile_h_in,
  input  logic                             rob_regfile_rst_in
);

  logic [DATA_W-1:0]    value_q [REG_COUNT];
  logic [DATA_W-1:0]    value_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [ROB_W-1:0]     tag_q [REG_COUNT];
  logic [ROB_W-1:0]     tag_d [REG_COUNT];

  // Commit first, then flush, then rename, so rename overrides a same-cycle clear.
  always_comb begin : next_state
    logic [REG_W-1:0] cd;
    logic [REG_W-1:0] rn;
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    cd      = '0;
    rn      = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      cd = rob_regfile_d_in[k*REG_W +: REG_W];
      if (rob_regfile_en_in[k] && (cd != '0)) begin
        value_d[cd] = rob_regfile_value_in[k*DATA_W +: DATA_W];
        // Compare against the pre-edge tag so every lane sees the same reference.
        if (tag_q[cd] == rob_regfile_h_in[k*ROB_W +: ROB_W]) begin
          busy_d[cd] = 1'b0;
          tag_d[cd]  = '0;
        end
      end
    end
    if (rob_regfile_rst_in) begin
      busy_d = '0;
      for (int r = 0; r < REG_COUNT; r++) begin
        tag_d[r] = '0;
      end
    end else begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        rn = dispatcher_regfile_rd_in[i*REG_W +: REG_W];
        if (dispatcher_regfile_rd_en_in[i] && (rn != '0)) begin
          busy_d[rn] = 1'b1;
          tag_d[rn]  = dispatcher_regfile_reorder_in[i*ROB_W +: ROB_W];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int r = 0; r < REG_COUNT; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
    end else if (rdy_in) begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  for (genvar j = 0; j < DISPATCH_WIDTH; j++) begin : g_lane
    localparam logic [DISPATCH_WIDTH-1:0] EarlierMask = DISPATCH_WIDTH'(lanes_below(j));

    logic [DISPATCH_WIDTH-1:0] earlier_en;
    assign earlier_en = dispatcher_regfile_rd_en_in & EarlierMask;

    regfile_mw_read #(
      .DISPATCH_WIDTH(DISPATCH_WIDTH),
      .COMMIT_WIDTH  (COMMIT_WIDTH),
      .REG_COUNT     (REG_COUNT),
      .REG_W         (REG_W),
      .DATA_W        (DATA_W),
      .ROB_W         (ROB_W)
    ) u_rs (
      .idx_i      (dispatcher_regfile_rs_in[j*REG_W +: REG_W]),
      .values_i   (value_q),
      .busy_i     (busy_q),
      .tags_i     (tag_q),
      .ren_en_i   (earlier_en),
      .ren_rd_i   (dispatcher_regfile_rd_in),
      .ren_tag_i  (dispatcher_regfile_reorder_in),
      .cmt_en_i   (rob_regfile_en_in),
      .cmt_d_i    (rob_regfile_d_in),
      .cmt_value_i(rob_regfile_value_in),
      .cmt_h_i    (rob_regfile_h_in),
      .busy_o     (regfile_dispatcher_rs_busy_out[j]),
      .value_o    (regfile_dispatcher_rs_out[j*DATA_W +: DATA_W]),
      .tag_o      (regfile_dispatcher_rs_reorder_out[j*ROB_W +: ROB_W])
    );

    regfile_mw_read #(
      .DISPATCH_WIDTH(DISPATCH_WIDTH),
      .COMMIT_WIDTH  (COMMIT_WIDTH),
      .REG_COUNT     (REG_COUNT),
      .REG_W         (REG_W),
      .DATA_W        (DATA_W),
      .ROB_W         (ROB_W)
    ) u_rt (
      .idx_i      (dispatcher_regfile_rt_in[j*REG_W +: REG_W]),
      .values_i   (value_q),
      .busy_i     (busy_q),
      .tags_i     (tag_q),
      .ren_en_i   (earlier_en),
      .ren_rd_i   (dispatcher_regfile_rd_in),
      .ren_tag_i  (dispatcher_regfile_reorder_in),
      .cmt_en_i   (rob_regfile_en_in),
      .cmt_d_i    (rob_regfile_d_in),
      .cmt_value_i(rob_regfile_value_in),
      .cmt_h_i    (rob_regfile_h_in),
      .busy_o     (regfile_dispatcher_rt_busy_out[j]),
      .value_o    (regfile_dispatcher_rt_out[j*DATA_W +: DATA_W]),
      .tag_o      (regfile_dispatcher_rt_reorder_out[j*ROB_W +: ROB_W])
    );
  end

endmodule

// File: tb/tb_regfile_mw.sv
// Self-checking bench for regfile_mw: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_regfile_mw;

  localparam int D  = 2;
  localparam int C  = 2;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int N  = 32;

  logic            clk = 1'b0;
  logic            rst, rdy, flush;
  logic [D*RW-1:0] rs, rt, rd;
  logic [D-1:0]    rd_en;
  logic [D*TW-1:0] reorder;
  logic [C-1:0]    c_en;
  logic [C*RW-1:0] c_d;
  logic [C*DW-1:0] c_val;
  logic [C*TW-1:0] c_h;
  logic [D-1:0]    rs_busy, rt_busy;
  logic [D*DW-1:0] rs_val, rt_val;
  logic [D*TW-1:0] rs_tag, rt_tag;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_val  [N];
  logic          m_busy [N];
  logic [TW-1:0] m_tag  [N];

  always #5 clk = ~clk;

  regfile_mw dut (
    .clk_in                           (clk),
    .rst_in                           (rst),
    .rdy_in                           (rdy),
    .dispatcher_regfile_rs_in         (rs),
    .dispatcher_regfile_rt_in         (rt),
    .regfile_dispatcher_rs_busy_out   (rs_busy),
    .regfile_dispatcher_rt_busy_out   (rt_busy),
    .regfile_dispatcher_rs_out        (rs_val),
    .regfile_dispatcher_rt_out        (rt_val),
    .regfile_dispatcher_rs_reorder_out(rs_tag),
    .regfile_dispatcher_rt_reorder_out(rt_tag),
    .dispatcher_regfile_rd_en_in      (rd_en),
    .dispatcher_regfile_rd_in         (rd),
    .dispatcher_regfile_reorder_in    (reorder),
    .rob_regfile_en_in                (c_en),
    .rob_regfile_d_in                 (c_d),
    .rob_regfile_value_in             (c_val),
    .rob_regfile_h_in                 (c_h),
    .rob_regfile_rst_in               (flush)
  );

  // Reference model: what a source read should return right now.
  function automatic void model_read(input int j, input logic [RW-1:0] s, output logic b,
                                     output logic [DW-1:0] v, output logic [TW-1:0] t);
    b = 1'b0;
    v = '0;
    t = '0;
    if (s == 0) return;
    for (int i = j - 1; i >= 0; i--) begin
      if (rd_en[i] && rd[i*RW +: RW] == s) begin
        b = 1'b1;
        t = reorder[i*TW +: TW];
        return;
      end
    end
`ifdef REGFILE_COMMIT_BYPASS_EN
    for (int k = C - 1; k >= 0; k--) begin
      if (c_en[k] && c_d[k*RW +: RW] == s) begin
        if (c_h[k*TW +: TW] == m_tag[s]) begin
          v = c_val[k*DW +: DW];
          return;
        end
        break;
      end
    end
`endif
    b = m_busy[s];
    v = m_val[s];
    t = m_tag[s];
  endfunction

  // Reference model: state change at a rising edge.
  function automatic void model_step();
    logic          nb [N];
    logic [TW-1:0] nt [N];
    int            d;
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
      end
      return;
    end
    if (!rdy) return;
    nb = m_busy;
    nt = m_tag;
    for (int k = 0; k < C; k++) begin
      d = int'(c_d[k*RW +: RW]);
      if (c_en[k] && d != 0) begin
        m_val[d] = c_val[k*DW +: DW];
        if (c_h[k*TW +: TW] == m_tag[d]) begin
          nb[d] = 1'b0; nt[d] = '0;
        end
      end
    end
    if (flush) begin
      for (int r = 0; r < N; r++) begin
        nb[r] = 1'b0; nt[r] = '0;
      end
    end else begin
      for (int i = 0; i < D; i++) begin
        d = int'(rd[i*RW +: RW]);
        if (rd_en[i] && d != 0) begin
          nb[d] = 1'b1; nt[d] = reorder[i*TW +: TW];
        end
      end
    end
    m_busy = nb;
    m_tag  = nt;
  endfunction

  task automatic idle();
    rs = '0; rt = '0; rd = '0; rd_en = '0; reorder = '0;
    c_en = '0; c_d = '0; c_val = '0; c_h = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ren(input int i, input int r, input int t);
    rd_en[i] = 1'b1;
    rd[i*RW +: RW] = RW'(r);
    reorder[i*TW +: TW] = TW'(t);
  endtask

  task automatic set_cmt(input int k, input int d, input int h, input logic [DW-1:0] v);
    c_en[k] = 1'b1;
    c_d[k*RW +: RW] = RW'(d);
    c_h[k*TW +: TW] = TW'(h);
    c_val[k*DW +: DW] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    rs = {D{5'd3}}; rt = {D{5'd3}};
    #1;
    for (int j = 0; j < D; j++) begin
      checks++;
      if (rs_busy[j] !== 1'b0 || rs_val[j*DW +: DW] !== '0 || rs_tag[j*TW +: TW] !== '0) begin
        failures++;
        $display("FAIL reset_rs lane%0d: got busy=%0b val=%h tag=%0d want 0/0/0", j, rs_busy[j],
                 rs_val[j*DW +: DW], rs_tag[j*TW +: TW]);
      end
      checks++;
      if (rt_busy[j] !== 1'b0 || rt_val[j*DW +: DW] !== '0 || rt_tag[j*TW +: TW] !== '0) begin
        failures++;
        $display("FAIL reset_rt lane%0d: got busy=%0b val=%h tag=%0d want 0/0/0", j, rt_busy[j],
                 rt_val[j*DW +: DW], rt_tag[j*TW +: TW]);
      end
    end
    idle(); set_ren(0, 0, 5);
    #1;
    checks++;
    if (rs_busy[1] !== 1'b0 || rs_tag[TW +: TW] !== '0) begin
      failures++;
      $display("FAIL x0_fwd: got busy=%0b tag=%0d want busy=0 tag=0", rs_busy[1], rs_tag[TW +: TW]);
    end
    tick(); idle(); #1;
    checks++;
    if (rs_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL x0_rename: got busy=%0b want 0", rs_busy[0]);
    end
  endtask

  task automatic test_intra_bundle();
    idle();
    set_ren(0, 5, 3);
    rs = {5'd5, 5'd5};
    #1;
    checks++;
    if (rs_busy[1] !== 1'b1 || rs_tag[TW +: TW] !== 4'd3) begin
      failures++;
      $display("FAIL intra_fwd: got busy=%0b tag=%0d want busy=1 tag=3", rs_busy[1],
               rs_tag[TW +: TW]);
    end
    checks++;
    if (rs_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL intra_own_lane: got busy=%0b want 0", rs_busy[0]);
    end
    tick(); idle(); rs = {5'd5, 5'd5}; #1;
    checks++;
    if (rs_busy[0] !== 1'b1 || rs_tag[TW-1:0] !== 4'd3) begin
      failures++;
      $display("FAIL rename_visible: got busy=%0b tag=%0d want busy=1 tag=3", rs_busy[0],
               rs_tag[TW-1:0]);
    end
  endtask

  task automatic test_commit_same_reg();
    idle(); set_ren(0, 7, 2); tick();
    idle(); set_cmt(0, 7, 2, 32'hAB); set_cmt(1, 7, 6, 32'hCD); tick();
    idle(); rt = {5'd0, 5'd7}; #1;
    checks++;
    if (rt_busy[0] !== 1'b0 || rt_val[DW-1:0] !== 32'hCD || rt_tag[TW-1:0] !== '0) begin
      failures++;
      $display("FAIL commit_same_reg: got busy=%0b val=%h tag=%0d want busy=0 val=cd tag=0",
               rt_busy[0], rt_val[DW-1:0], rt_tag[TW-1:0]);
    end
  endtask

  task automatic test_commit_vs_rename();
    idle(); set_ren(1, 9, 4); tick();
    idle(); set_cmt(0, 9, 4, 32'h11); set_ren(0, 9, 8); tick();
    idle(); rs = {5'd9, 5'd0}; #1;
    checks++;
    if (rs_busy[1] !== 1'b1 || rs_tag[TW +: TW] !== 4'd8 || rs_val[DW +: DW] !== 32'h11) begin
      failures++;
      $display("FAIL commit_vs_rename: got busy=%0b tag=%0d val=%h want busy=1 tag=8 val=11",
               rs_busy[1], rs_tag[TW +: TW], rs_val[DW +: DW]);
    end
  endtask

  task automatic test_flush();
    idle(); set_ren(0, 2, 1); set_ren(1, 10, 7); tick();
    idle(); flush = 1'b1; set_cmt(0, 2, 9, 32'h55); set_ren(0, 4, 3); tick();
    idle(); rs = {5'd10, 5'd2}; rt = {5'd9, 5'd4}; #1;
    checks++;
    if (rs_busy !== 2'b00 || rt_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: got rs=%b rt0=%b want rs=00 rt0=0", rs_busy, rt_busy[0]);
    end
    checks++;
    if (rs_val[DW-1:0] !== 32'h55) begin
      failures++;
      $display("FAIL flush_commit_value: got %h want 55", rs_val[DW-1:0]);
    end
    checks++;
    if (rt_val[DW +: DW] !== 32'h11 || rt_busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL flush_x9: got val=%h busy=%0b want val=11 busy=0", rt_val[DW +: DW],
               rt_busy[1]);
    end
  endtask

  task automatic test_bypass();
    idle(); set_ren(0, 6, 1); tick();
    idle(); set_cmt(1, 6, 1, 32'h99); rs = {5'd0, 5'd6}; #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
    checks++;
    if (rs_busy[0] !== 1'b0 || rs_val[DW-1:0] !== 32'h99 || rs_tag[TW-1:0] !== '0) begin
      failures++;
      $display("FAIL bypass: got busy=%0b val=%h tag=%0d want busy=0 val=99 tag=0",
               rs_busy[0], rs_val[DW-1:0], rs_tag[TW-1:0]);
    end
`else
    checks++;
    if (rs_busy[0] !== 1'b1 || rs_tag[TW-1:0] !== 4'd1) begin
      failures++;
      $display("FAIL no_bypass: got busy=%0b tag=%0d want busy=1 tag=1", rs_busy[0],
               rs_tag[TW-1:0]);
    end
`endif
    tick(); idle(); rs = {5'd0, 5'd6}; #1;
    checks++;
    if (rs_busy[0] !== 1'b0 || rs_val[DW-1:0] !== 32'h99) begin
      failures++;
      $display("FAIL commit_visible: got busy=%0b val=%h want busy=0 val=99", rs_busy[0],
               rs_val[DW-1:0]);
    end
  endtask

  task automatic test_hold_and_reset();
    idle(); rdy = 1'b0; set_ren(0, 12, 5); set_cmt(0, 2, 0, 32'h77); tick();
    rdy = 1'b1; idle(); rs = {5'd2, 5'd12}; #1;
    checks++;
    if (rs_busy[0] !== 1'b0 || rs_val[DW +: DW] !== 32'h55) begin
      failures++;
      $display("FAIL rdy_hold: got busy=%0b x2=%h want busy=0 x2=55", rs_busy[0],
               rs_val[DW +: DW]);
    end
    idle(); set_ren(0, 13, 3); tick();
    idle(); rst = 1'b1; set_ren(1, 14, 2); set_cmt(0, 2, 0, 32'h66); tick();
    rst = 1'b0; idle(); rs = {5'd2, 5'd13}; rt = {5'd14, 5'd14}; #1;
    checks++;
    if (rs_busy !== 2'b00 || rs_val[DW +: DW] !== '0 || rt_busy !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid: got rs_busy=%b x2=%h rt_busy=%b want 00/0/00", rs_busy,
               rs_val[DW +: DW], rt_busy);
    end
  endtask

  task automatic test_random();
    logic          eb;
    logic [DW-1:0] ev;
    logic [TW-1:0] et;
    logic [RW-1:0] s;
    for (int n = 0; n < 400; n++) begin
      idle();
      rst   = ($urandom_range(0, 63) == 0);
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < D; i++) begin
        rs[i*RW +: RW] = RW'($urandom_range(0, 7));
        rt[i*RW +: RW] = RW'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) set_ren(i, $urandom_range(0, 7), $urandom_range(0, 15));
      end
      for (int k = 0; k < C; k++) begin
        if ($urandom_range(0, 1) == 1)
          set_cmt(k, $urandom_range(0, 7), $urandom_range(0, 15), $urandom());
      end
      #1;
      for (int j = 0; j < D; j++) begin
        s = rs[j*RW +: RW];
        model_read(j, s, eb, ev, et);
        checks++;
        if (rs_busy[j] !== eb || rs_val[j*DW +: DW] !== ev || rs_tag[j*TW +: TW] !== et) begin
          failures++;
          $display("FAIL rand_rs n=%0d lane%0d x%0d: got %0b/%h/%0d want %0b/%h/%0d", n, j, s,
                   rs_busy[j], rs_val[j*DW +: DW], rs_tag[j*TW +: TW], eb, ev, et);
        end
        s = rt[j*RW +: RW];
        model_read(j, s, eb, ev, et);
        checks++;
        if (rt_busy[j] !== eb || rt_val[j*DW +: DW] !== ev || rt_tag[j*TW +: TW] !== et) begin
          failures++;
          $display("FAIL rand_rt n=%0d lane%0d x%0d: got %0b/%h/%0d want %0b/%h/%0d", n, j, s,
                   rt_busy[j], rt_val[j*DW +: DW], rt_tag[j*TW +: TW], eb, ev, et);
        end
      end
      tick();
    end
    rst = 1'b0; rdy = 1'b1; idle();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; idle();
    tick(); tick();
    test_reset();
    test_intra_bundle();
    test_commit_same_reg();
    test_commit_vs_rename();
    test_flush();
    test_bypass();
    test_hold_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
